vga_480p_deser: RTL

- Capture-side counterpart of the 480p VGA serializer.
- Takes digitised 8b R/G/B samples plus active-low hsync/vsync from an ADC front end, recovers 640x480@60 timing and verifies it.
- Emits packed pixels with screen-space indices and a write strobe for a framebuffer or CDC FIFO.
- Sits between the video ADC pins and the frame-capture logic, in the pixel clock domain.

---
 rtl/vga_480p_deser.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vga_480p_deser.sv
// Capture-side 640x480@60 deserializer: registers ADC samples, recovers raster
// position from hsync/vsync, verifies the timing and emits indexed pixels once locked.
module vga_480p_deser #(
  parameter int H_OFFSET    = 0,
  parameter int LOCK_FRAMES = 2,
  // Raster geometry; the defaults are standard 480p and exist so the timing can be scaled.
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_START     = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_START     = 35,
  parameter int V_ACTIVE    = 480
) (
  input  logic        clk_25_175M,
  input  logic        rst_n,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [23:0] pix_out,
  output logic        pix_valid,
  output logic [9:0]  hidx,
  output logic [9:0]  vidx,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_count
);

  localparam logic [9:0] CNT_MAX     = 10'd1023;
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LEN  = 10'(H_SYNC);
  localparam logic [9:0] H_BEG       = 10'(H_START + H_OFFSET);
  localparam logic [9:0] H_END       = 10'(H_START + H_OFFSET + H_ACTIVE);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_LEN  = 10'(V_SYNC);
  localparam logic [9:0] V_BEG       = 10'(V_START);
  localparam logic [9:0] V_END       = 10'(V_START + V_ACTIVE);
  localparam logic [7:0] GOOD_TARGET = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state;
  logic [7:0]  good;
  logic [23:0] rgb_q;
  logic        hs_q, vs_q, hs_prev, vs_prev;
  logic [9:0]  p_reg, l_reg;
  logic        vs_pend;
  logic        len_valid;

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [9:0]  pos, line;
  logic        err, visible, valid_d;
  logic [7:0]  good_inc;

  always_ff @(posedge clk_25_175M or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      rgb_q   <= {b_in, g_in, r_in};
      hs_q    <= hsync_in;
      vs_q    <= vsync_in;
      hs_prev <= hs_q;
      vs_prev <= vs_q;
    end
  end

  assign hs_fall = !hs_q && hs_prev;
  assign hs_rise = hs_q && !hs_prev;
  assign vs_fall = !vs_q && vs_prev;
  assign vs_rise = vs_q && !vs_prev;
  assign good_inc = good + 8'd1;

  // pos/line describe the sample currently held in stage 1; a vsync edge seen
  // anywhere in a line makes the next hsync edge start line 0.
  always_comb begin
    pos = (p_reg == CNT_MAX) ? CNT_MAX : p_reg + 10'd1;
    if (hs_fall) pos = '0;
    line = l_reg;
    if (hs_fall) begin
      if (vs_fall || vs_pend) line = '0;
      else line = (l_reg == CNT_MAX) ? CNT_MAX : l_reg + 10'd1;
    end
  end

  always_comb begin
    err = 1'b0;
    if (hs_fall && len_valid && (p_reg != H_LAST)) err = 1'b1;
    if (hs_rise && (pos != H_SYNC_LEN))            err = 1'b1;
    if ((pos == CNT_MAX) && (p_reg != CNT_MAX))    err = 1'b1;
    if (vs_fall && (l_reg != V_LAST))              err = 1'b1;
    if (vs_rise && (line != V_SYNC_LEN))           err = 1'b1;
  end

  assign visible = (pos >= H_BEG) && (pos < H_END) && (line >= V_BEG) && (line < V_END);
  assign valid_d = visible && (state == LOCKED) && !err;

  always_ff @(posedge clk_25_175M or negedge rst_n) begin
    if (!rst_n) begin
      p_reg     <= '0;
      l_reg     <= '0;
      vs_pend   <= 1'b0;
      len_valid <= 1'b0;
    end else begin
      p_reg <= pos;
      l_reg <= line;
      if (hs_fall)      vs_pend <= 1'b0;
      else if (vs_fall) vs_pend <= 1'b1;
      // The line that ended in an error gives no trustworthy length reference.
      if (err && (state != SEARCH)) len_valid <= 1'b0;
      else if (hs_fall)             len_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk_25_175M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      good      <= '0;
      locked    <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        SEARCH: begin
          locked <= 1'b0;
          if (vs_fall) begin
            state <= ACQUIRE;
            good  <= '0;
          end
        end
        ACQUIRE: begin
          if (err) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end else if (vs_fall) begin
            good <= good_inc;
            if (good_inc >= GOOD_TARGET) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (err) begin
            state  <= SEARCH;
            locked <= 1'b0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_25_175M or negedge rst_n) begin
    if (!rst_n) begin
      pix_out     <= '0;
      pix_valid   <= 1'b0;
      hidx        <= '0;
      vidx        <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_out     <= rgb_q;
      pix_valid   <= valid_d;
      hidx        <= valid_d ? pos - H_BEG : '0;
      vidx        <= valid_d ? line - V_BEG : '0;
      frame_start <= valid_d && (pos == H_BEG) && (line == V_BEG);
    end
  end

endmodule
